// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and default geometry for the data-cache controller
// and the dcache datapath.
//   dcache_state_t : controller state encoding
//   DCACHE_WORDS   : default words per cache block
//   DCACHE_FRAMES  : default number of frames walked during flush
package dcache_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    WB      = 4'd1,
    READ    = 4'd2,
    SNP_WB  = 4'd3,
    SNP_INV = 4'd4,
    FL_CHK  = 4'd5,
    FL_WB   = 4'd6,
    FL_NEXT = 4'd7,
    HALT    = 4'd8
  } dcache_state_t;

  localparam int DCACHE_WORDS  = 2;
  localparam int DCACHE_FRAMES = 16;

endpackage

// File: rtl/up_counter.sv
// up_counter: saturating up-counter with synchronous clear.
//   CLK, nRST : clock, asynchronous active-low reset
//   clear     : synchronous clear to 0 (wins over enable)
//   enable    : increment by one, saturating at MAX
//   count     : current value
//   at_max    : count == MAX
module up_counter #(
  parameter int W   = 1,
  parameter int MAX = 1
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != MAX_V)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX_V);

endmodule

// File: rtl/dcache_ctrl_fsm.sv
// dcache_ctrl_fsm: data-cache control FSM. Sequences miss refills, dirty-block
// writebacks, coherence snoops and the end-of-program flush/halt.
//   CLK, nRST          : clock, asynchronous active-low reset
//   dmemREN, dmemWEN   : datapath read/write request
//   flush              : datapath halt request, flush all dirty frames
//   dhit               : current request hits
//   dirty              : addressed (or frame_idx-selected when flushing) block dirty
//   dwait              : memory busy; a word completes in a cycle with dwait=0
//   ccwait             : coherence controller holds the cache for a snoop
//   ccwrite, ccinv     : snoop needs writeback / invalidate only
//   dREN, dWEN         : memory read/write strobe
//   word_sel           : word index of the current transfer
//   invalid            : clear valid/dirty of the current block this cycle
//   idle, flushing     : FSM in IDLE / flush in progress
//   frame_idx          : frame under flush
//   halt               : flush complete, sticky until reset
//
// state   | meaning
// IDLE    | waiting for miss, flush or snoop
// WB      | writing back dirty victim block before refill
// READ    | refilling block from memory
// SNP_WB  | writing back snooped block
// SNP_INV | one-cycle invalidate of snooped clean block
// FL_CHK  | testing frame frame_idx for dirty / end of flush
// FL_WB   | writing back dirty frame during flush
// FL_NEXT | advancing frame_idx
// HALT    | flush done, held until reset
module dcache_ctrl_fsm
  import dcache_pkg::*;
#(
  parameter int WORDS  = DCACHE_WORDS,
  parameter int FRAMES = DCACHE_FRAMES,
  parameter int WW     = (WORDS > 1) ? $clog2(WORDS) : 1,
  parameter int FW     = $clog2(FRAMES + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          dmemREN,
  input  logic          dmemWEN,
  input  logic          flush,
  input  logic          dhit,
  input  logic          dirty,
  input  logic          dwait,
  input  logic          ccwait,
  input  logic          ccwrite,
  input  logic          ccinv,
  output logic          dREN,
  output logic          dWEN,
  output logic [WW-1:0] word_sel,
  output logic          invalid,
  output logic          idle,
  output logic          flushing,
  output logic [FW-1:0] frame_idx,
  output logic          halt
);

  dcache_state_t state_q, state_d;

  logic [WW-1:0] wcnt;
  logic          wcnt_last;
  logic [FW-1:0] fcnt;
  logic          fcnt_end;
  logic          xfer;
  logic          word_done;
  logic          xfer_done;
  logic          miss;

  assign miss      = (dmemREN | dmemWEN) & ~dhit;
  assign xfer      = (state_q == WB) || (state_q == READ) ||
                     (state_q == SNP_WB) || (state_q == FL_WB);
  assign word_done = xfer & ~dwait;
  // The word counter returns to 0 on the same edge the FSM leaves the
  // transfer state, so every transfer starts at word 0.
  assign xfer_done = word_done & wcnt_last;

  up_counter #(.W(WW), .MAX(WORDS - 1)) u_wcnt (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (xfer_done),
    .enable (word_done),
    .count  (wcnt),
    .at_max (wcnt_last)
  );

  // Saturates at FRAMES; only reset returns it to 0 since HALT is terminal.
  up_counter #(.W(FW), .MAX(FRAMES)) u_fcnt (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (1'b0),
    .enable (state_q == FL_NEXT),
    .count  (fcnt),
    .at_max (fcnt_end)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A miss during a snoop hold is deferred until ccwait drops.
        if (miss && !ccwait)          state_d = dirty ? WB : READ;
        else if (flush)               state_d = FL_CHK;
        else if (ccwait && ccwrite)   state_d = SNP_WB;
        else if (ccwait && ccinv)     state_d = SNP_INV;
      end
      WB:      if (xfer_done) state_d = READ;
      READ:    if (xfer_done) state_d = IDLE;
      SNP_WB:  if (xfer_done) state_d = IDLE;
      SNP_INV: state_d = IDLE;
      FL_CHK: begin
        if (fcnt_end)   state_d = HALT;
        else if (dirty) state_d = FL_WB;
        else            state_d = FL_NEXT;
      end
      FL_WB:   if (xfer_done) state_d = FL_NEXT;
      FL_NEXT: state_d = FL_CHK;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dREN      = 1'b0;
    dWEN      = 1'b0;
    invalid   = 1'b0;
    idle      = 1'b0;
    flushing  = 1'b0;
    halt      = 1'b0;
    word_sel  = wcnt;
    frame_idx = fcnt;
    case (state_q)
      IDLE:    idle = 1'b1;
      WB: begin
        dWEN    = 1'b1;
        invalid = wcnt_last;
      end
      READ:    dREN = 1'b1;
      SNP_WB: begin
        dWEN    = 1'b1;
        invalid = wcnt_last;
      end
      SNP_INV: invalid = 1'b1;
      FL_CHK:  flushing = 1'b1;
      FL_WB: begin
        dWEN     = 1'b1;
        invalid  = wcnt_last;
        flushing = 1'b1;
      end
      FL_NEXT: flushing = 1'b1;
      HALT:    halt = 1'b1;
      default: idle = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
module tb_dcache_ctrl_fsm;
  import dcache_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic dmemREN = 0, dmemWEN = 0, flush = 0, dhit = 0, dirty = 0, dwait = 0;
  logic ccwait = 0, ccwrite = 0, ccinv = 0;

  // WORDS=2, FRAMES=16 instance
  logic       d2_dREN, d2_dWEN, d2_inv, d2_idle, d2_fl, d2_halt;
  logic [0:0] d2_ws;
  logic [4:0] d2_fi;
  // WORDS=4, FRAMES=4 instance
  logic       d4_dREN, d4_dWEN, d4_inv, d4_idle, d4_fl, d4_halt;
  logic [1:0] d4_ws;
  logic [2:0] d4_fi;

  typedef logic [12:0] ov_t;  // {dREN,dWEN,ws[1:0],invalid,idle,flushing,fi[4:0],halt}
  ov_t sb_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  always #5 CLK = ~CLK;

  dcache_ctrl_fsm #(.WORDS(2), .FRAMES(16)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .flush(flush),
    .dhit(dhit), .dirty(dirty), .dwait(dwait), .ccwait(ccwait), .ccwrite(ccwrite),
    .ccinv(ccinv), .dREN(d2_dREN), .dWEN(d2_dWEN), .word_sel(d2_ws), .invalid(d2_inv),
    .idle(d2_idle), .flushing(d2_fl), .frame_idx(d2_fi), .halt(d2_halt)
  );

  dcache_ctrl_fsm #(.WORDS(4), .FRAMES(4)) u_dut4 (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .flush(flush),
    .dhit(dhit), .dirty(dirty), .dwait(dwait), .ccwait(ccwait), .ccwrite(ccwrite),
    .ccinv(ccinv), .dREN(d4_dREN), .dWEN(d4_dWEN), .word_sel(d4_ws), .invalid(d4_inv),
    .idle(d4_idle), .flushing(d4_fl), .frame_idx(d4_fi), .halt(d4_halt)
  );

  function automatic ov_t ex(input bit rd, input bit wr, input int ws, input bit inv,
                             input bit idl, input bit fl, input int fi, input bit h);
    logic [1:0] w2;
    logic [4:0] f5;
    w2 = ws[1:0];
    f5 = fi[4:0];
    return {rd, wr, w2, inv, idl, fl, f5, h};
  endfunction

  function automatic ov_t obs2();
    return {d2_dREN, d2_dWEN, 1'b0, d2_ws, d2_inv, d2_idle, d2_fl, d2_fi, d2_halt};
  endfunction

  function automatic ov_t obs4();
    return {d4_dREN, d4_dWEN, d4_ws, d4_inv, d4_idle, d4_fl, 2'b00, d4_fi, d4_halt};
  endfunction

  task automatic set_in(input bit ren, input bit wen, input bit hit, input bit drt,
                        input bit dw, input bit fls, input bit ccw, input bit ccwr,
                        input bit cci);
    dmemREN = ren; dmemWEN = wen; dhit = hit; dirty = drt; dwait = dw;
    flush = fls; ccwait = ccw; ccwrite = ccwr; ccinv = cci;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    ov_t got, want;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    #2;
    sb_q.push_back(ex(0, 0, 0, 0, 1, 0, 0, 0));
    sb_q.push_back(ex(0, 0, 0, 0, 1, 0, 0, 0));
    got = obs2(); want = sb_q.pop_front(); n_chk++;
    if (got !== want) begin n_err++; $display("FAIL reset_w2: got=%b want=%b", got, want); end
    got = obs4(); want = sb_q.pop_front(); n_chk++;
    if (got !== want) begin n_err++; $display("FAIL reset_w4: got=%b want=%b", got, want); end
    @(posedge CLK); #1;
    nRST = 1'b1;
    sb_q.push_back(ex(0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge CLK); #1;
    got = obs2(); want = sb_q.pop_front(); n_chk++;
    if (got !== want) begin n_err++; $display("FAIL reset_release: got=%b want=%b", got, want); end
  endtask

  // WORDS=4 clean read miss, dwait=0
  task automatic test_clean_read();
    ov_t got, want;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      else        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (i < 4) sb_q.push_back(ex(1, 0, i, 0, 0, 0, 0, 0));
      else       sb_q.push_back(ex(0, 0, 0, 0, 1, 0, 0, 0));
      @(posedge CLK); #1;
      got = obs4(); want = sb_q.pop_front(); n_chk++;
      if (got !== want) begin n_err++; $display("FAIL clean_read cyc%0d: got=%b want=%b", i, got, want); end
    end
  endtask

  // WORDS=2 dirty write miss, dwait high 3 cycles on word 1
  task automatic test_dirty_write();
    ov_t got, want;
    ov_t e [8];
    bit  dw [8];
    dw = '{0, 0, 1, 1, 1, 0, 0, 0};
    e[0] = ex(0, 1, 0, 0, 0, 0, 0, 0);
    e[1] = ex(0, 1, 1, 1, 0, 0, 0, 0);
    e[2] = e[1]; e[3] = e[1]; e[4] = e[1];
    e[5] = ex(1, 0, 0, 0, 0, 0, 0, 0);
    e[6] = ex(1, 0, 1, 0, 0, 0, 0, 0);
    e[7] = ex(0, 0, 0, 0, 1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) set_in(0, 1, 0, 1, 0, 0, 0, 0, 0);
      else        set_in(0, 0, 0, 0, dw[i], 0, 0, 0, 0);
      sb_q.push_back(e[i]);
      @(posedge CLK); #1;
      got = obs2(); want = sb_q.pop_front(); n_chk++;
      if (got !== want) begin n_err++; $display("FAIL dirty_write cyc%0d: got=%b want=%b", i, got, want); end
    end
  endtask

  // Snoop writeback with a simultaneous miss: snoop first, miss after ccwait drops
  task automatic test_snoop_wb();
    ov_t got, want;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0, 1: set_in(1, 0, 0, 0, 0, 0, 1, 1, 0);
        2, 3: set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);
        4:    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        default: set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      case (i)
        0: sb_q.push_back(ex(0, 1, 0, 0, 0, 0, 0, 0));
        1: sb_q.push_back(ex(0, 1, 1, 1, 0, 0, 0, 0));
        4: sb_q.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0));
        5: sb_q.push_back(ex(1, 0, 1, 0, 0, 0, 0, 0));
        default: sb_q.push_back(ex(0, 0, 0, 0, 1, 0, 0, 0));
      endcase
      @(posedge CLK); #1;
      got = obs2(); want = sb_q.pop_front(); n_chk++;
      if (got !== want) begin n_err++; $display("FAIL snoop_wb cyc%0d: got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_snoop_inv();
    ov_t got, want;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
        sb_q.push_back(ex(0, 0, 0, 1, 0, 0, 0, 0));
      end else begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_q.push_back(ex(0, 0, 0, 0, 1, 0, 0, 0));
      end
      @(posedge CLK); #1;
      got = obs2(); want = sb_q.pop_front(); n_chk++;
      if (got !== want) begin n_err++; $display("FAIL snoop_inv cyc%0d: got=%b want=%b", i, got, want); end
    end
  endtask

  // ccwrite beats ccinv; miss beats flush
  task automatic test_priority();
    ov_t got, want;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
        3: set_in(1, 0, 0, 0, 0, 1, 0, 0, 0);
        default: set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      case (i)
        0: sb_q.push_back(ex(0, 1, 0, 0, 0, 0, 0, 0));
        1: sb_q.push_back(ex(0, 1, 1, 1, 0, 0, 0, 0));
        3: sb_q.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0));
        4: sb_q.push_back(ex(1, 0, 1, 0, 0, 0, 0, 0));
        default: sb_q.push_back(ex(0, 0, 0, 0, 1, 0, 0, 0));
      endcase
      @(posedge CLK); #1;
      got = obs2(); want = sb_q.pop_front(); n_chk++;
      if (got !== want) begin n_err++; $display("FAIL priority cyc%0d: got=%b want=%b", i, got, want); end
    end
  endtask

  // Flush with frames 3 and 15 dirty, then halt held under random inputs
  task automatic test_flush();
    ov_t got, want;
    dcache_state_t m_st;
    int  m_f, m_w, fl_cycles, f0, f1;
    int  wb_frames[$];
    bit  drt, got_halt;
    logic [31:0] r;
    m_st = IDLE; m_f = 0; m_w = 0; fl_cycles = 0; got_halt = 0;
    do_reset();
    for (int c = 0; c < 200 && !got_halt; c++) begin
      drt = (m_f == 3) || (m_f == 15);
      set_in(0, 0, 0, drt, 0, c == 0, 0, 0, 0);
      case (m_st)
        IDLE:    m_st = FL_CHK;
        FL_CHK: begin
          if (m_f == 16)  m_st = HALT;
          else if (drt) begin m_st = FL_WB; m_w = 0; end
          else            m_st = FL_NEXT;
        end
        FL_WB:   if (m_w == 1) begin m_w = 0; m_st = FL_NEXT; end else m_w++;
        FL_NEXT: begin m_f++; m_st = FL_CHK; end
        default: m_st = m_st;
      endcase
      sb_q.push_back(ex(0, m_st == FL_WB, m_w, (m_st == FL_WB) && (m_w == 1), 0,
                        (m_st == FL_CHK) || (m_st == FL_WB) || (m_st == FL_NEXT),
                        m_f, m_st == HALT));
      @(posedge CLK); #1;
      got = obs2(); want = sb_q.pop_front(); n_chk++;
      if (got !== want) begin n_err++; $display("FAIL flush cyc%0d: got=%b want=%b", c, got, want); end
      if (d2_fl) fl_cycles++;
      if (d2_dWEN && d2_fl && (d2_ws == 1'b0)) wb_frames.push_back(int'(d2_fi));
      if (d2_halt) got_halt = 1;
    end
    n_chk++;
    if (got_halt !== 1'b1) begin n_err++; $display("FAIL flush_halt_timeout: halt=%b want=1", got_halt); end
    n_chk++;
    if (fl_cycles !== 37) begin n_err++; $display("FAIL flush_cycles: got=%0d want=37", fl_cycles); end
    f0 = -1; f1 = -1;
    if (wb_frames.size() > 0) f0 = wb_frames[0];
    if (wb_frames.size() > 1) f1 = wb_frames[1];
    n_chk++;
    if (wb_frames.size() != 2 || f0 != 3 || f1 != 15) begin
      n_err++;
      $display("FAIL flush_wb_frames: got n=%0d f0=%0d f1=%0d want n=2 f0=3 f1=15", wb_frames.size(), f0, f1);
    end
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      set_in(r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7], r[8]);
      sb_q.push_back(ex(0, 0, 0, 0, 0, 0, 16, 1));
      @(posedge CLK); #1;
      got = obs2(); want = sb_q.pop_front(); n_chk++;
      if (got !== want) begin n_err++; $display("FAIL halt_sticky cyc%0d: got=%b want=%b", i, got, want); end
    end
  endtask

  // Reset asserted in the last word of an FL_WB at frame 1
  task automatic test_reset_mid_flwb();
    ov_t got, want;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, i == 3, 0, i == 0, 0, 0, 0);
      case (i)
        0, 1: sb_q.push_back(ex(0, 0, 0, 0, 0, 1, 0, 0));
        2:    sb_q.push_back(ex(0, 0, 0, 0, 0, 1, 1, 0));
        3:    sb_q.push_back(ex(0, 1, 0, 0, 0, 1, 1, 0));
        default: sb_q.push_back(ex(0, 1, 1, 1, 0, 1, 1, 0));
      endcase
      @(posedge CLK); #1;
      got = obs2(); want = sb_q.pop_front(); n_chk++;
      if (got !== want) begin n_err++; $display("FAIL pre_reset_flwb cyc%0d: got=%b want=%b", i, got, want); end
    end
    nRST = 1'b0;
    #1;
    sb_q.push_back(ex(0, 0, 0, 0, 1, 0, 0, 0));
    got = obs2(); want = sb_q.pop_front(); n_chk++;
    if (got !== want) begin n_err++; $display("FAIL reset_mid_flwb_async: got=%b want=%b", got, want); end
    sb_q.push_back(ex(0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge CLK); #1;
    got = obs2(); want = sb_q.pop_front(); n_chk++;
    if (got !== want) begin n_err++; $display("FAIL reset_mid_flwb_next: got=%b want=%b", got, want); end
    nRST = 1'b1;
    sb_q.push_back(ex(0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge CLK); #1;
    got = obs2(); want = sb_q.pop_front(); n_chk++;
    if (got !== want) begin n_err++; $display("FAIL reset_mid_flwb_release: got=%b want=%b", got, want); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_read();
    test_dirty_write();
    test_snoop_wb();
    test_snoop_inv();
    test_priority();
    test_flush();
    test_reset_mid_flwb();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
